jump_charge_ctl: RTL and testbench

// - Jump sequencer for the player rectangle: converts keyboard levels into charged-jump launch commands.
// - Hold space on ground -> charge builds; release (or full charge) -> one launch request with velocities, held until the physics block acks.
// - Sits between keyboard decoder and player physics/position block; gates walking while charging or airborne.

---
 rtl/jk_pkg.sv | 32 +++
 rtl/ms_tick_gen.sv | 35 +++
 rtl/jump_charge_ctl.sv | 175 +++++++++++++++++
 tb/tb_jump_charge_ctl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and constants for the jump sequencer and its tick source.
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHARGE   = 3'd1,
    LAUNCH   = 3'd2,
    AIRBORNE = 3'd3,
    COOLDOWN = 3'd4
  } jump_state_t;

  localparam int CHARGE_W = 5;
  localparam int VEL_W    = 8;

  localparam logic [1:0] WALK_NONE  = 2'b00;
  localparam logic [1:0] WALK_RIGHT = 2'b01;
  localparam logic [1:0] WALK_LEFT  = 2'b10;

  // Opposing direction keys cancel out.
  function automatic logic [1:0] walk_decode(input logic left, input logic right);
    logic [1:0] dir;
    if (right && !left) begin
      dir = WALK_RIGHT;
    end else if (left && !right) begin
      dir = WALK_LEFT;
    end else begin
      dir = WALK_NONE;
    end
    return dir;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick: one-cycle registered pulse each time the
// cycle counter wraps; cleared only by reset.
module ms_tick_gen #(
  parameter int CLOCKS_PER_MS = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (CLOCKS_PER_MS > 1) ? $clog2(CLOCKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;

  // Cycle counter with registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == CNT_LAST);
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/jump_charge_ctl.sv
// Charged-jump sequencer: turns space/left/right levels into a held launch
// request with latched velocities, and gates walking outside IDLE.
module jump_charge_ctl
  import jk_pkg::*;
#(
  parameter int CLOCKS_PER_MS  = 1_000_000,
  parameter int CHARGE_STEP_MS = 20,
  parameter int CHARGE_MAX     = 31,
  parameter int VY_MIN         = 4,
  parameter int VX_JUMP        = 3,
  parameter int COOLDOWN_MS    = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_space,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                on_ground,
  input  logic                jump_ack,
  output logic                jump_req,
  output logic [VEL_W-1:0]    jump_vy,
  output logic [VEL_W-1:0]    jump_vx,
  output logic [1:0]          walk_dir,
  output logic [CHARGE_W-1:0] charge_lvl
);

  localparam int CNT_MAX = (CHARGE_STEP_MS > COOLDOWN_MS) ? CHARGE_STEP_MS : COOLDOWN_MS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(CHARGE_STEP_MS - 1);
  localparam logic [CNT_W-1:0]    COOL_LAST = CNT_W'(COOLDOWN_MS - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CHARGE_W-1:0] CHG_MAX   = CHARGE_W'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] CHG_ONE   = CHARGE_W'(1);
  localparam logic [VEL_W-1:0]    VY_BASE   = VEL_W'(VY_MIN);
  localparam logic [VEL_W-1:0]    VX_POS    = VEL_W'(VX_JUMP);
  localparam logic [VEL_W-1:0]    VX_NEG    = VEL_W'(0) - VX_POS;

  jump_state_t         state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CHARGE_W-1:0] charge_r;
  logic                need_release_r;
  logic                ground_q_r;
  logic                jump_req_r;
  logic [VEL_W-1:0]    vx_r;
  logic [VEL_W-1:0]    vy_r;
  logic [1:0]          walk_r;

  logic                tick_s;
  logic [1:0]          walk_keys_s;
  logic [VEL_W-1:0]    launch_vx_s;
  logic                rise_s;

  ms_tick_gen #(
    .CLOCKS_PER_MS(CLOCKS_PER_MS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst),
    .tick (tick_s)
  );

  assign walk_keys_s = walk_decode(key_left, key_right);
  assign rise_s      = on_ground && !ground_q_r;

  // Horizontal launch speed from the keys seen in the launch decision cycle.
  always_comb begin
    launch_vx_s = '0;
    case (walk_keys_s)
      WALK_RIGHT: launch_vx_s = VX_POS;
      WALK_LEFT:  launch_vx_s = VX_NEG;
      default:    launch_vx_s = '0;
    endcase
  end

  // State, shared step/cooldown counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      charge_r       <= '0;
      need_release_r <= 1'b1;
      ground_q_r     <= 1'b0;
      jump_req_r     <= 1'b0;
      vx_r           <= '0;
      vy_r           <= '0;
      walk_r         <= WALK_NONE;
    end else begin
      ground_q_r <= on_ground;
      walk_r     <= WALK_NONE;
      // A held space key must be let go before the next charge can start.
      if (state_r == LAUNCH && jump_ack) begin
        need_release_r <= 1'b1;
      end else if (!key_space) begin
        need_release_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!on_ground) begin
            state_r <= AIRBORNE;
          end else if (key_space && !need_release_r) begin
            state_r  <= CHARGE;
            charge_r <= '0;
            cnt_r    <= '0;
          end else begin
            walk_r <= walk_keys_s;
          end
        end
        CHARGE: begin
          if (!on_ground) begin
            state_r  <= AIRBORNE;
            charge_r <= '0;
            cnt_r    <= '0;
          end else if (!key_space || charge_r == CHG_MAX) begin
            state_r    <= LAUNCH;
            jump_req_r <= 1'b1;
            vy_r       <= VY_BASE + VEL_W'(charge_r);
            vx_r       <= launch_vx_s;
          end else if (tick_s) begin
            if (cnt_r == STEP_LAST) begin
              cnt_r <= '0;
              if (charge_r != CHG_MAX) begin
                charge_r <= charge_r + CHG_ONE;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        LAUNCH: begin
          if (jump_ack) begin
            state_r    <= AIRBORNE;
            jump_req_r <= 1'b0;
            vx_r       <= '0;
            vy_r       <= '0;
            charge_r   <= '0;
          end
        end
        AIRBORNE: begin
          if (rise_s) begin
            state_r <= COOLDOWN;
            cnt_r   <= '0;
          end
        end
        COOLDOWN: begin
          if (!on_ground) begin
            state_r <= AIRBORNE;
          end else if (tick_s) begin
            if (cnt_r == COOL_LAST) begin
              state_r <= IDLE;
              cnt_r   <= '0;
              walk_r  <= walk_keys_s;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= '0;
          charge_r   <= '0;
          jump_req_r <= 1'b0;
          vx_r       <= '0;
          vy_r       <= '0;
        end
      endcase
    end
  end

  assign jump_req   = jump_req_r;
  assign jump_vy    = vy_r;
  assign jump_vx    = vx_r;
  assign walk_dir   = walk_r;
  assign charge_lvl = charge_r;

endmodule

// File: tb/tb_jump_charge_ctl.sv
// Randomised and directed bench for jump_charge_ctl with a behavioural model.
module tb_jump_charge_ctl;

  localparam int CPM   = 4;
  localparam int STEP  = 2;
  localparam int CMAX  = 31;
  localparam int VYMIN = 4;
  localparam int VX    = 3;
  localparam int COOL  = 3;

  localparam int M_IDLE = 0, M_CHG = 1, M_LAUNCH = 2, M_AIR = 3, M_COOL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_space = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       on_ground = 1'b1, jump_ack = 1'b0;
  logic       jump_req;
  logic [7:0] jump_vy, jump_vx;
  logic [1:0] walk_dir;
  logic [4:0] charge_lvl;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit saw_req = 1'b0;

  // model state
  int m_mode, m_ms, m_ticks, m_cool, m_vy, m_vx, m_walk;
  bit m_tq, m_need, m_gprev;

  jump_charge_ctl #(
    .CLOCKS_PER_MS(CPM), .CHARGE_STEP_MS(STEP), .CHARGE_MAX(CMAX),
    .VY_MIN(VYMIN), .VX_JUMP(VX), .COOLDOWN_MS(COOL)
  ) dut (
    .clk(clk), .rst(rst), .key_space(key_space), .key_left(key_left),
    .key_right(key_right), .on_ground(on_ground), .jump_ack(jump_ack),
    .jump_req(jump_req), .jump_vy(jump_vy), .jump_vx(jump_vx),
    .walk_dir(walk_dir), .charge_lvl(charge_lvl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dir_of(input bit l, input bit r);
    if (r && !l) return 1;
    if (l && !r) return 2;
    return 0;
  endfunction

  function automatic int m_charge();
    int c;
    c = m_ticks / STEP;
    return (c > CMAX) ? CMAX : c;
  endfunction

  function automatic int e_charge();
    return (m_mode == M_CHG || m_mode == M_LAUNCH) ? m_charge() : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ms = 0; m_tq = 1'b0; m_ticks = 0; m_cool = 0;
    m_vy = 0; m_vx = 0; m_walk = 0; m_need = 1'b1; m_gprev = 1'b0;
  endtask

  task automatic model_step();
    bit tick, rise, set_need;
    int nm, d;
    tick = m_tq;
    m_tq = (m_ms == CPM - 1);
    m_ms = (m_ms == CPM - 1) ? 0 : m_ms + 1;
    rise = on_ground && !m_gprev;
    d = dir_of(key_left, key_right);
    nm = m_mode;
    set_need = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (!on_ground) nm = M_AIR;
        else if (key_space && !m_need) begin nm = M_CHG; m_ticks = 0; end
      end
      M_CHG: begin
        if (!on_ground) begin nm = M_AIR; m_ticks = 0; end
        else if (!key_space || m_charge() == CMAX) begin
          nm = M_LAUNCH;
          m_vy = VYMIN + m_charge();
          m_vx = (d == 1) ? VX : (d == 2) ? -VX : 0;
        end else if (tick) m_ticks++;
      end
      M_LAUNCH: if (jump_ack) begin nm = M_AIR; m_ticks = 0; set_need = 1'b1; end
      M_AIR: if (rise) begin nm = M_COOL; m_cool = 0; end
      M_COOL: begin
        if (!on_ground) nm = M_AIR;
        else if (tick) begin
          m_cool++;
          if (m_cool == COOL) nm = M_IDLE;
        end
      end
      default: nm = M_IDLE;
    endcase
    if (set_need) m_need = 1'b1;
    else if (!key_space) m_need = 1'b0;
    m_mode = nm;
    m_gprev = on_ground;
    m_walk = (nm == M_IDLE) ? d : 0;
  endtask

  // reference model tracking the DUT clock and async reset
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (jump_req) saw_req = 1'b1;
      if (cmp_en) begin
        check("req", int'(jump_req), (m_mode == M_LAUNCH) ? 1 : 0);
        check("vy", int'(jump_vy), (m_mode == M_LAUNCH) ? m_vy : 0);
        check("vx", int'($signed(jump_vx)), (m_mode == M_LAUNCH) ? m_vx : 0);
        check("walk", int'(walk_dir), m_walk);
        check("charge", int'(charge_lvl), e_charge());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset state
    cyc(3);
    check("rst_req", int'(jump_req), 0);
    check("rst_vy", int'(jump_vy), 0);
    check("rst_vx", int'(jump_vx), 0);
    check("rst_walk", int'(walk_dir), 0);
    check("rst_charge", int'(charge_lvl), 0);
    key_space = 1'b1;
    rst = 1'b1;
    cmp_en = 1'b1;
    cyc(20);
    check("held_after_rst_charge", int'(charge_lvl), 0);
    check("held_after_rst_req", int'(jump_req), 0);
    key_space = 1'b0;
    cyc(2);

    // short jump to the right: 41 held cycles always span exactly 10 ticks
    key_right = 1'b1;
    key_space = 1'b1;
    cyc(41);
    key_space = 1'b0;
    cyc(1);
    check("short_req", int'(jump_req), 1);
    check("short_vy", int'(jump_vy), 9);
    check("short_vx", int'($signed(jump_vx)), 3);
    check("short_charge", int'(charge_lvl), 5);
    check("model_short_vy", m_vy, 9);
    key_right = 1'b0;
    cyc(3);
    check("short_req_held", int'(jump_req), 1);
    jump_ack = 1'b1;
    cyc(1);
    jump_ack = 1'b0;
    cyc(1);
    check("ack_clears_req", int'(jump_req), 0);
    check("ack_clears_vy", int'(jump_vy), 0);
    on_ground = 1'b0;
    cyc(5);
    on_ground = 1'b1;
    cyc(20);
    check("model_back_idle", m_mode, M_IDLE);

    // full charge, then land with space still held
    key_space = 1'b1;
    cyc(300);
    check("full_req", int'(jump_req), 1);
    check("full_vy", int'(jump_vy), 35);
    check("full_vx", int'($signed(jump_vx)), 0);
    check("full_charge", int'(charge_lvl), 31);
    check("model_full_vy", m_vy, 35);
    jump_ack = 1'b1;   // same-cycle-as-first-req case is covered in random phase too
    cyc(1);
    jump_ack = 1'b0;
    on_ground = 1'b0;
    cyc(5);
    on_ground = 1'b1;
    cyc(30);
    check("land_no_recharge_charge", int'(charge_lvl), 0);
    check("land_no_recharge_req", int'(jump_req), 0);
    key_left = 1'b1;
    cyc(2);
    check("walk_left", int'(walk_dir), 2);
    key_right = 1'b1;
    cyc(2);
    check("walk_both", int'(walk_dir), 0);

    // both keys at release give vx 0; reset mid-launch drops req at once
    key_space = 1'b0;
    cyc(2);
    key_space = 1'b1;
    cyc(10);
    key_space = 1'b0;
    cyc(2);
    check("both_req", int'(jump_req), 1);
    check("both_vx", int'($signed(jump_vx)), 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", int'(jump_req), 0);
    check("async_rst_vy", int'(jump_vy), 0);
    check("async_rst_charge", int'(charge_lvl), 0);
    key_left = 1'b0;
    key_right = 1'b0;
    cyc(3);
    key_space = 1'b1;
    rst = 1'b1;
    cyc(20);
    check("rst_space_held_req", int'(jump_req), 0);
    check("rst_space_held_charge", int'(charge_lvl), 0);
    key_space = 1'b0;
    cyc(2);

    // walking off a ledge while charging
    key_space = 1'b1;
    cyc(20);
    saw_req = 1'b0;
    on_ground = 1'b0;
    cyc(2);
    check("ledge_charge", int'(charge_lvl), 0);
    cyc(10);
    key_space = 1'b0;
    cyc(2);
    check("ledge_never_req", int'(saw_req), 0);
    on_ground = 1'b1;
    cyc(20);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) on_ground = ~on_ground;
      if ($urandom_range(0, 99) < 5) key_space = ~key_space;
      if ($urandom_range(0, 99) < 10) key_left = ~key_left;
      if ($urandom_range(0, 99) < 10) key_right = ~key_right;
      jump_ack = ($urandom_range(0, 9) == 0);
    end
    jump_ack = 1'b0;
    cyc(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
